// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared ALU adder for one job at a time.
// Produces the low WIDTH bits of op_a*op_b after exactly WIDTH accumulate iterations.
module alu_mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_operand_A,
  output logic [WIDTH-1:0] alu_operand_B,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_NOP = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = op_a;
          q_d     = op_b;
          p_d     = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (q_q[0]) p_d = alu_result;
        m_d   = m_q << 1;
        q_d   = q_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        // The last iteration's sum is taken straight from the ALU so no extra cycle is spent.
        if (cnt_q == CNT_LAST) begin
          product_d = q_q[0] ? alu_result : p_q;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      m_q       <= m_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // ALU-facing outputs are forced to zero whenever the ALU is not owned by this block.
  always_comb begin
    busy          = (state_q == S_RUN);
    done          = (state_q == S_DONE);
    alu_own       = busy;
    alu_operand_A = busy ? p_q : '0;
    alu_operand_B = busy ? m_q : '0;
    alu_control   = (busy && q_q[0]) ? ALU_ADD : ALU_NOP;
    product       = product_q;
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: directed and random jobs against an arithmetic model,
// with a behavioural ALU (ADD for 3'b100, an unrelated function otherwise).
module tb_alu_mul_sequencer;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done, alu_own;
  logic [WIDTH-1:0] product, alu_operand_A, alu_operand_B, alu_result;
  logic [2:0]       alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations of the most recent job, filled by do_job.
  logic [WIDTH-1:0] obs_a [WIDTH];
  logic [WIDTH-1:0] obs_b [WIDTH];
  logic [2:0]       obs_c [WIDTH];
  int               busy_n;
  int               done_at;
  logic [WIDTH-1:0] prod_obs;

  alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op_a          (op_a),
    .op_b          (op_b),
    .busy          (busy),
    .done          (done),
    .product       (product),
    .alu_own       (alu_own),
    .alu_operand_A (alu_operand_A),
    .alu_operand_B (alu_operand_B),
    .alu_control   (alu_control),
    .alu_result    (alu_result)
  );

  assign alu_result = (alu_control == 3'b100) ? alu_operand_A + alu_operand_B
                                              : alu_operand_A ^ alu_operand_B ^ 32'hA5A5_0F0F;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: accumulator after i iterations = a * (low i bits of b), modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] exp_p(input logic [WIDTH-1:0] a, b, input int i);
    logic [WIDTH-1:0] mask;
    mask = (i == 0) ? '0 : ({WIDTH{1'b1}} >> (WIDTH - i));
    return a * (b & mask);
  endfunction

  function automatic int trace_errs(input logic [WIDTH-1:0] a, b);
    int errs = 0;
    logic [WIDTH-1:0] sh;
    for (int i = 0; i < WIDTH; i++) begin
      sh = a << i;
      if (obs_a[i] !== exp_p(a, b, i) || obs_b[i] !== sh || obs_c[i] !== (b[i] ? 3'b100 : 3'b000))
        errs++;
    end
    return errs;
  endfunction

  function automatic int add_cycles();
    int n = 0;
    for (int i = 0; i < WIDTH; i++) if (obs_c[i] == 3'b100) n++;
    return n;
  endfunction

  // Called in an IDLE cycle (1ns after an edge). Returns one cycle after done, back in IDLE.
  task automatic do_job(input logic [WIDTH-1:0] a, b, input bit hold, input bit scramble);
    int j;
    start = 1'b1; op_a = a; op_b = b;
    step();
    if (!hold) start = 1'b0;
    busy_n = 0; done_at = -1; j = 0; prod_obs = 'x;
    while (done_at < 0 && j <= WIDTH + 4) begin
      if (busy) begin
        if (busy_n < WIDTH) begin
          obs_a[busy_n] = alu_operand_A;
          obs_b[busy_n] = alu_operand_B;
          obs_c[busy_n] = alu_control;
        end
        busy_n++;
      end
      if (done) begin
        done_at  = j;
        prod_obs = product;
      end else begin
        if (scramble) begin op_a = $urandom; op_b = $urandom; end
        step();
        j++;
      end
    end
    if (done_at >= 0) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; op_a = $urandom; op_b = $urandom;
    step(); step();
    reset = 1'b0; start = 1'b0;
    if ({busy, done, alu_own} !== 3'b000) begin
      $display("FAIL reset_flags busy/done/own got %b want 000", {busy, done, alu_own}); n_fail++;
    end
    n_checks++;
    if (product !== '0) begin
      $display("FAIL reset_product got %h want 0", product); n_fail++;
    end
    n_checks++;
    if (alu_operand_A !== '0 || alu_operand_B !== '0 || alu_control !== 3'b000) begin
      $display("FAIL reset_alu_outputs got A=%h B=%h C=%b want zeros", alu_operand_A, alu_operand_B, alu_control);
      n_fail++;
    end
    n_checks++;
    step();
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_stays got busy=%b want 0", busy); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] ta [4] = '{32'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'd7};
    logic [WIDTH-1:0] tb [4] = '{32'd5, 32'hFFFF_FFFF, 32'h0001_0000, 32'd0};
    logic [WIDTH-1:0] exp;
    for (int k = 0; k < 4; k++) begin
      exp = ta[k] * tb[k];
      do_job(ta[k], tb[k], 1'b0, 1'b0);
      if (done_at !== WIDTH || busy_n !== WIDTH) begin
        $display("FAIL directed%0d_latency got done_at=%0d busy=%0d want %0d/%0d", k, done_at, busy_n, WIDTH, WIDTH);
        n_fail++;
      end
      n_checks++;
      if (prod_obs !== exp) begin
        $display("FAIL directed%0d_product got %h want %h", k, prod_obs, exp); n_fail++;
      end
      n_checks++;
      if (trace_errs(ta[k], tb[k]) != 0) begin
        $display("FAIL directed%0d_alu_trace got %0d bad cycles want 0", k, trace_errs(ta[k], tb[k])); n_fail++;
      end
      n_checks++;
      if (add_cycles() != $countones(tb[k])) begin
        $display("FAIL directed%0d_add_count got %0d want %0d", k, add_cycles(), $countones(tb[k])); n_fail++;
      end
      n_checks++;
      if ({busy, done, alu_own} !== 3'b000 || product !== exp) begin
        $display("FAIL directed%0d_after_done got flags=%b product=%h want 000/%h", k, {busy, done, alu_own}, product, exp);
        n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_hold_start();
    do_job(32'd2, 32'd9, 1'b1, 1'b0);
    if (done_at !== WIDTH || prod_obs !== 32'd18) begin
      $display("FAIL hold_first_job got done_at=%0d product=%h want %0d/00000012", done_at, prod_obs, WIDTH); n_fail++;
    end
    n_checks++;
    step();
    if (busy !== 1'b1) begin
      $display("FAIL hold_restart got busy=%b want 1", busy); n_fail++;
    end
    n_checks++;
    start = 1'b0;
    for (int j = 0; j < WIDTH + 4 && !done; j++) step();
    if (done !== 1'b1 || product !== 32'd18) begin
      $display("FAIL hold_second_job got done=%b product=%h want 1/00000012", done, product); n_fail++;
    end
    n_checks++;
    step();
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    start = 1'b1; op_a = 32'd6; op_b = 32'd7;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    if ({busy, alu_own} !== 2'b00 || alu_control !== 3'b000 || product !== '0) begin
      $display("FAIL midrun_reset got busy/own=%b ctrl=%b product=%h want 00/000/0", {busy, alu_own}, alu_control, product);
      n_fail++;
    end
    n_checks++;
    for (int j = 0; j < WIDTH + 8; j++) begin
      if (done) pulses++;
      step();
    end
    if (pulses != 0 || product !== '0) begin
      $display("FAIL midrun_no_done got pulses=%0d product=%h want 0/0", pulses, product); n_fail++;
    end
    n_checks++;
    do_job(32'd6, 32'd7, 1'b0, 1'b0);
    if (prod_obs !== 32'd42) begin
      $display("FAIL midrun_rerun got %h want 0000002a", prod_obs); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_operand_churn();
    do_job(32'd4, 32'd4, 1'b0, 1'b1);
    if (prod_obs !== 32'd16 || done_at !== WIDTH) begin
      $display("FAIL churn_product got %h done_at=%0d want 00000010/%0d", prod_obs, done_at, WIDTH); n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b;
    int bad = 0;
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      b = (k % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      do_job(a, b, 1'b0, 1'b0);
      if (prod_obs !== a * b || done_at !== WIDTH || trace_errs(a, b) != 0) begin
        $display("FAIL random%0d a=%h b=%h got product=%h done_at=%0d want %h/%0d", k, a, b, prod_obs, done_at, a * b, WIDTH);
        n_fail++;
        bad++;
      end
      n_checks++;
      if (bad > 4) break;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    #2;
    test_reset();
    test_directed();
    test_hold_start();
    test_random();
    test_reset_mid_run();
    test_operand_churn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
